// File: rtl/lsu_mem_req_pkg.sv
// Shared types for the load/store request unit: error codes, FSM states and
// the data_mem port structures carried over the flattened port buses.
package lsu_mem_req_pkg;

    typedef enum logic [1:0] {
        LSU_ERR_NONE     = 2'd0,
        LSU_ERR_MISALIGN = 2'd1,
        LSU_ERR_RANGE    = 2'd2,
        LSU_ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] read_data;
        logic        yumi;
    } mem_out_s;

    localparam int MEM_IN_W  = $bits(mem_in_s);
    localparam int MEM_OUT_W = $bits(mem_out_s);

    // An address is in range only when no bit above the memory's byte-address width is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/lsu_mem_req_load_extend.sv
// Load-data formatter: passes whole words through, or zero/sign-extends the
// low byte of the returned data for byte loads.
module lsu_load_extend (
    input  logic [31:0] rdata,
    input  logic        byte_sel,
    input  logic        sign_ext,
    output logic [31:0] data
);

    always_comb begin
        data = rdata;
        if (byte_sel) begin
            data = {{24{sign_ext & rdata[7]}}, rdata[7:0]};
        end
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Load/store request unit between the MEM stage and data_mem: one request in
// flight, local rejection of bad addresses and timeouts, single buffered response.
module lsu_mem_req
    import lsu_mem_req_pkg::*;
#(
    parameter int addr_width_p = 12,
    parameter int timeout_p    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_addr_i,
    input  logic                 req_wen_i,
    input  logic                 req_byte_i,
    input  logic                 req_signed_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic [1:0]           rsp_err_o,
    output logic                 stall_o,
    output logic [MEM_IN_W-1:0]  mem_port_flat_o,
    output logic [31:0]          mem_addr_o,
    input  logic [MEM_OUT_W-1:0] mem_port_flat_i
);

    localparam int CNT_W = $clog2(timeout_p + 1);

    lsu_state_e  state_q, state_n;
    logic [31:0] addr_q, addr_n;
    logic        wen_q, wen_n;
    logic        byte_q, byte_n;
    logic        signed_q, signed_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] rsp_data_q, rsp_data_n;
    lsu_err_e    rsp_err_q, rsp_err_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    mem_in_s     mem_in;
    mem_out_s    mem_out;
    logic [31:0] load_data;

    assign mem_out = mem_port_flat_i;

    lsu_load_extend u_load_extend (
        .rdata    (mem_out.read_data),
        .byte_sel (byte_q),
        .sign_ext (signed_q),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            byte_q     <= 1'b0;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= LSU_ERR_NONE;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            wen_q      <= wen_n;
            byte_q     <= byte_n;
            signed_q   <= signed_n;
            wdata_q    <= wdata_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            cnt_q      <= cnt_n;
        end
    end

    // Outside WAIT any memory response is a stray late reply, so it is
    // acknowledged and dropped; only REQ ever raises valid toward memory.
    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        wen_n      = wen_q;
        byte_n     = byte_q;
        signed_n   = signed_q;
        wdata_n    = wdata_q;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        cnt_n      = cnt_q;
        req_ready_o          = 1'b0;
        mem_in               = '0;
        mem_in.wen           = wen_q;
        mem_in.byte_not_word = byte_q;
        mem_in.write_data    = wdata_q;

        case (state_q)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                mem_in.yumi = mem_out.valid;
                if (req_valid_i) begin
                    addr_n     = req_addr_i;
                    wen_n      = req_wen_i;
                    byte_n     = req_byte_i;
                    signed_n   = req_signed_i;
                    wdata_n    = req_wdata_i;
                    rsp_data_n = '0;
                    rsp_err_n  = LSU_ERR_NONE;
                    if (!req_byte_i && (req_addr_i[1:0] != 2'b00)) begin
                        rsp_err_n = LSU_ERR_MISALIGN;
                        state_n   = LSU_RESP;
                    end else if (!addr_in_range(req_addr_i, addr_width_p)) begin
                        rsp_err_n = LSU_ERR_RANGE;
                        state_n   = LSU_RESP;
                    end else begin
                        state_n = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                mem_in.valid = 1'b1;
                if (mem_out.yumi) begin
                    cnt_n   = '0;
                    state_n = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                mem_in.yumi = mem_out.valid;
                if (mem_out.valid) begin
                    rsp_data_n = wen_q ? 32'd0 : load_data;
                    rsp_err_n  = LSU_ERR_NONE;
                    state_n    = LSU_RESP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_n == CNT_W'(timeout_p)) begin
                        rsp_data_n = '0;
                        rsp_err_n  = LSU_ERR_TIMEOUT;
                        state_n    = LSU_RESP;
                    end
                end
            end
            LSU_RESP: begin
                mem_in.yumi = mem_out.valid;
                if (rsp_ready_i) begin
                    state_n = LSU_IDLE;
                end
            end
            default: begin
                state_n = LSU_IDLE;
            end
        endcase
    end

    assign rsp_valid_o     = (state_q == LSU_RESP);
    assign rsp_data_o      = rsp_data_q;
    assign rsp_err_o       = rsp_err_q;
    assign stall_o         = req_valid_i & ~req_ready_o;
    assign mem_port_flat_o = mem_in;
    assign mem_addr_o      = addr_q;

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req with a byte-addressed data_mem model whose
// response delay can be stretched to provoke timeouts and late replies.
module tb_lsu_mem_req;
    import lsu_mem_req_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [31:0]          req_addr_i;
    logic                 req_wen_i;
    logic                 req_byte_i;
    logic                 req_signed_i;
    logic [31:0]          req_wdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [31:0]          rsp_data_o;
    logic [1:0]           rsp_err_o;
    logic                 stall_o;
    logic [MEM_IN_W-1:0]  mem_port_flat_o;
    logic [31:0]          mem_addr_o;
    logic [MEM_OUT_W-1:0] mem_port_flat_i;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_req #(.addr_width_p(12), .timeout_p(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_wen_i       (req_wen_i),
        .req_byte_i      (req_byte_i),
        .req_signed_i    (req_signed_i),
        .req_wdata_i     (req_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_err_o       (rsp_err_o),
        .stall_o         (stall_o),
        .mem_port_flat_o (mem_port_flat_o),
        .mem_addr_o      (mem_addr_o),
        .mem_port_flat_i (mem_port_flat_i)
    );

    always #5 clk = ~clk;

    // Memory model: accepts a request in the cycle valid is seen, answers
    // respDelay cycles later and holds valid until the unit acknowledges.
    mem_in_s     mi;
    mem_out_s    mo;
    logic [7:0]  mem [4096];
    logic        mvR = 1'b0;
    logic [31:0] rdR = '0;
    int          pendCnt = 0;
    int          respDelay = 1;
    int          memValidCount = 0;
    int          handshakeCount = 0;

    assign mi              = mem_port_flat_o;
    assign mo.valid        = mvR;
    assign mo.read_data    = rdR;
    assign mo.yumi         = mi.valid;
    assign mem_port_flat_i = mo;

    always @(posedge clk) begin
        logic [11:0] a;
        a = mem_addr_o[11:0];
        if (mi.valid) memValidCount <= memValidCount + 1;
        if (mvR && mi.yumi) begin
            mvR <= 1'b0;
            handshakeCount <= handshakeCount + 1;
        end
        if (pendCnt != 0) begin
            pendCnt <= pendCnt - 1;
            if (pendCnt == 1) mvR <= 1'b1;
        end
        if (mi.valid && mo.yumi) begin
            if (mi.wen) begin
                mem[a] <= mi.write_data[7:0];
                if (!mi.byte_not_word) begin
                    mem[a + 12'd1] <= mi.write_data[15:8];
                    mem[a + 12'd2] <= mi.write_data[23:16];
                    mem[a + 12'd3] <= mi.write_data[31:24];
                end
                rdR <= '0;
            end else if (mi.byte_not_word) begin
                rdR <= {24'd0, mem[a]};
            end else begin
                rdR <= {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
            end
            if (respDelay <= 1) mvR <= 1'b1;
            else pendCnt <= respDelay - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in the accept cycle and returns in the cycle after.
    task automatic applyStimulus(input logic [31:0] addr, input logic wen, input logic isByte,
                                 input logic sgn, input logic [31:0] wdata);
        req_addr_i   = addr;
        req_wen_i    = wen;
        req_byte_i   = isByte;
        req_signed_i = sgn;
        req_wdata_i  = wdata;
        req_valid_i  = 1'b1;
        #1;
        checkOutput("accept_ready", {31'd0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic waitRsp(output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 64) begin
            step();
            lat++;
        end
        if (!rsp_valid_o) checkOutput("rsp_timeout_bound", 32'd0, 32'd1);
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int lat;
        int snapV;
        int snapH;
        logic [31:0] heldData;
        logic        anyRsp;

        reset = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_wen_i = 1'b0; req_byte_i = 1'b0;
        req_signed_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b0;
        repeat (3) step();
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("reset_rsp_data", rsp_data_o, 32'd0);
        checkOutput("reset_rsp_err", {30'd0, rsp_err_o}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
        checkOutput("reset_mem_valid", {31'd0, mi.valid}, 32'd0);
        reset = 1'b0;
        step();
        checkOutput("idle_ready", {31'd0, req_ready_o}, 32'd1);

        applyStimulus(32'h010, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        waitRsp(lat);
        checkOutput("wst_latency", lat, 32'd3);
        checkOutput("wst_err", {30'd0, rsp_err_o}, 32'd0);
        checkOutput("wst_data", rsp_data_o, 32'd0);
        consume();
        checkOutput("wst_mem", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]}, 32'hDEADBEEF);

        applyStimulus(32'h010, 1'b0, 1'b0, 1'b0, 32'h0);
        waitRsp(lat);
        checkOutput("wld_latency", lat, 32'd3);
        checkOutput("wld_data", rsp_data_o, 32'hDEADBEEF);
        checkOutput("wld_err", {30'd0, rsp_err_o}, 32'd0);
        consume();

        applyStimulus(32'h021, 1'b1, 1'b1, 1'b0, 32'h12345680);
        waitRsp(lat);
        checkOutput("bst_err", {30'd0, rsp_err_o}, 32'd0);
        consume();
        checkOutput("bst_mem", {24'd0, mem[12'h021]}, 32'h80);

        applyStimulus(32'h021, 1'b0, 1'b1, 1'b1, 32'h0);
        waitRsp(lat);
        checkOutput("bld_signed", rsp_data_o, 32'hFFFFFF80);
        consume();
        applyStimulus(32'h021, 1'b0, 1'b1, 1'b0, 32'h0);
        waitRsp(lat);
        checkOutput("bld_unsigned", rsp_data_o, 32'h00000080);
        consume();

        snapV = memValidCount;
        applyStimulus(32'h013, 1'b0, 1'b0, 1'b0, 32'h0);
        waitRsp(lat);
        checkOutput("mis_latency", lat, 32'd1);
        checkOutput("mis_err", {30'd0, rsp_err_o}, 32'(LSU_ERR_MISALIGN));
        checkOutput("mis_data", rsp_data_o, 32'd0);
        consume();
        checkOutput("mis_no_mem_valid", memValidCount - snapV, 32'd0);

        applyStimulus(32'h000, 1'b1, 1'b1, 1'b0, 32'h5A);
        waitRsp(lat);
        consume();
        snapV = memValidCount;
        applyStimulus(32'h1000, 1'b1, 1'b1, 1'b0, 32'hAA);
        waitRsp(lat);
        checkOutput("rng_latency", lat, 32'd1);
        checkOutput("rng_err", {30'd0, rsp_err_o}, 32'(LSU_ERR_RANGE));
        consume();
        checkOutput("rng_no_mem_valid", memValidCount - snapV, 32'd0);
        checkOutput("rng_mem_unchanged", {24'd0, mem[12'h000]}, 32'h5A);

        // Accept 0, REQ 1, WAIT 2..17, timeout response in cycle 18; late valid in cycle 21.
        respDelay = 20;
        snapH = handshakeCount;
        applyStimulus(32'h010, 1'b0, 1'b0, 1'b0, 32'h0);
        waitRsp(lat);
        checkOutput("to_latency", lat, 32'd18);
        checkOutput("to_err", {30'd0, rsp_err_o}, 32'(LSU_ERR_TIMEOUT));
        checkOutput("to_data", rsp_data_o, 32'd0);
        consume();
        anyRsp = 1'b0;
        repeat (8) begin
            anyRsp |= rsp_valid_o;
            step();
        end
        checkOutput("to_no_second_rsp", {31'd0, anyRsp}, 32'd0);
        checkOutput("to_late_yumi", handshakeCount - snapH, 32'd1);
        respDelay = 1;

        applyStimulus(32'h010, 1'b0, 1'b0, 1'b0, 32'h0);
        waitRsp(lat);
        heldData = rsp_data_o;
        checkOutput("hold_first_data", heldData, 32'hDEADBEEF);
        req_addr_i  = 32'h020;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("hold_valid_%0d", i), {31'd0, rsp_valid_o}, 32'd1);
            checkOutput($sformatf("hold_data_%0d", i), rsp_data_o, 32'hDEADBEEF);
            checkOutput($sformatf("hold_ready_%0d", i), {31'd0, req_ready_o}, 32'd0);
            checkOutput($sformatf("hold_stall_%0d", i), {31'd0, stall_o}, 32'd1);
            step();
        end
        req_valid_i = 1'b0;
        consume();
        checkOutput("hold_released", {31'd0, rsp_valid_o}, 32'd0);

        respDelay = 10;
        snapH = handshakeCount;
        applyStimulus(32'h010, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_wait_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("rst_wait_ready", {31'd0, req_ready_o}, 32'd1);
        checkOutput("rst_wait_mem_addr", mem_addr_o, 32'd0);
        anyRsp = 1'b0;
        repeat (12) begin
            anyRsp |= rsp_valid_o;
            step();
        end
        checkOutput("rst_wait_no_rsp", {31'd0, anyRsp}, 32'd0);
        checkOutput("rst_wait_late_yumi", handshakeCount - snapH, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "[TB] time limit");
    end

endmodule
